alu_pin_sequencer: RTL and testbench

Multi-cycle, handshake-driven ALU front end for the Tiny Tapeout user-project pin interface. A host loads operand A and then operand B plus an opcode over `ui_in` with a strobe on `uio_in[0]`. The block executes the operation, with an 8-cycle shift-add multiply, and presents a 16-bit result and flags on `uo_out`/`uio_out` until the host acknowledges. It is the responder to the bench/host that drives the top-level pins, and sits directly under the `tt_um_*` top wrapper.

---
 rtl/alu_pin_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_alu_pin_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_pin_sequencer.sv
// Handshake-driven 8-bit ALU behind the Tiny Tapeout pin interface.
// A host loads A, then B and an opcode. MUL uses an 8-step shift-add.
module alu_pin_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GOT_A = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  state_t      state_q, state_d;
  logic        stb_q, stb_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] r_q, r_d;
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;

  logic        evt_s;
  logic [8:0]  sum_s;
  logic [15:0] alu_r_s;
  logic        alu_c_s;
  logic [15:0] mul_acc_s;
  logic        busy_s;
  logic        done_s;
  logic        unused_s;

  assign unused_s = &{1'b0, uio_in[7:4]};

  // Single-cycle opcode datapath plus one shift-add step of the multiplier.
  always_comb begin
    evt_s     = uio_in[0] & ~stb_q & ena;
    sum_s     = {1'b0, a_q} + {1'b0, b_q};
    alu_r_s   = 16'h0000;
    alu_c_s   = 1'b0;
    mul_acc_s = acc_q + (b_q[cnt_q] ? ({8'h00, a_q} << cnt_q) : 16'h0000);
    case (op_q)
      OP_ADD: begin
        alu_r_s = {8'h00, sum_s[7:0]};
        alu_c_s = sum_s[8];
      end
      OP_SUB: begin
        alu_r_s = {8'h00, a_q - b_q};
        alu_c_s = (a_q < b_q);
      end
      OP_AND:  alu_r_s = {8'h00, a_q & b_q};
      OP_OR:   alu_r_s = {8'h00, a_q | b_q};
      OP_XOR:  alu_r_s = {8'h00, a_q ^ b_q};
      OP_SHL:  alu_r_s = {8'h00, a_q << b_q[2:0]};
      OP_SHR:  alu_r_s = {8'h00, a_q >> b_q[2:0]};
      default: begin
        alu_r_s = 16'h0000;
        alu_c_s = 1'b0;
      end
    endcase
  end

  // Sequencer next state; with ena low every register holds.
  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    r_d     = r_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (ena) begin
      stb_d = uio_in[0];
      case (state_q)
        S_IDLE: begin
          if (evt_s) begin
            a_d     = ui_in;
            state_d = S_GOT_A;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_GOT_A: begin
          if (evt_s) begin
            b_d     = ui_in;
            op_d    = uio_in[3:1];
            cnt_d   = 3'd0;
            acc_d   = 16'h0000;
            state_d = S_EXEC;
          end else begin
            state_d = S_GOT_A;
          end
        end
        S_EXEC: begin
          if (op_q == OP_MUL) begin
            acc_d = mul_acc_s;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              r_d     = mul_acc_s;
              carry_d = (mul_acc_s[15:8] != 8'h00);
              zero_d  = (mul_acc_s == 16'h0000);
              state_d = S_DONE;
            end else begin
              state_d = S_EXEC;
            end
          end else begin
            r_d     = alu_r_s;
            carry_d = alu_c_s;
            zero_d  = (alu_r_s == 16'h0000);
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (evt_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stb_q   <= 1'b0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      op_q    <= 3'd0;
      cnt_q   <= 3'd0;
      acc_q   <= 16'h0000;
      r_q     <= 16'h0000;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  // Result byte select is a live mux on uio_in[3] while DONE.
  always_comb begin
    busy_s = (state_q == S_EXEC);
    done_s = (state_q == S_DONE);
    if (done_s) begin
      uo_out = uio_in[3] ? r_q[15:8] : r_q[7:0];
    end else begin
      uo_out = 8'h00;
    end
    uio_out = {zero_q, carry_q, done_s, busy_s, 4'h0};
    uio_oe  = 8'hF0;
  end

endmodule

// File: tb/tb_alu_pin_sequencer.sv
// Directed self-checking bench for alu_pin_sequencer.
module tb_alu_pin_sequencer;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  integer errors = 0;
  integer checks = 0;

  alu_pin_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One strobe cycle followed by one quiet cycle.
  task automatic strobe_byte(input logic [7:0] d, input logic [2:0] op);
    ui_in  = d;
    uio_in = {4'h0, op, 1'b1};
    tick;
    uio_in = 8'h00;
    tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    #3;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo: got %h expected 00", uo_out); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio_out: got %h expected 00", uio_out); end
    checks++; if (uio_oe !== 8'hF0) begin errors++; $display("FAIL reset_uio_oe: got %h expected F0", uio_oe); end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_add;
    strobe_byte(8'd200, 3'd0);
    ui_in = 8'd100; uio_in = 8'h01;
    tick;
    checks++; if (uio_out[5:4] !== 2'b01) begin errors++; $display("FAIL add_busy: got %b expected 01", uio_out[5:4]); end
    uio_in = 8'h00;
    tick;
    checks++; if (uio_out[5:4] !== 2'b10) begin errors++; $display("FAIL add_done: got %b expected 10", uio_out[5:4]); end
    checks++; if (uo_out !== 8'h2C) begin errors++; $display("FAIL add_lo: got %h expected 2C", uo_out); end
    checks++; if (uio_out[7:6] !== 2'b01) begin errors++; $display("FAIL add_flags: got %b expected 01", uio_out[7:6]); end
    uio_in = 8'h08; #1;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL add_hi: got %h expected 00", uo_out); end
    uio_in = 8'h00; #1;
    strobe_byte(8'h00, 3'd0);
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL add_ack_uo: got %h expected 00", uo_out); end
    checks++; if (uio_out[5:4] !== 2'b00) begin errors++; $display("FAIL add_ack_state: got %b expected 00", uio_out[5:4]); end
  endtask

  task automatic test_sub_xor;
    strobe_byte(8'd5, 3'd0);
    strobe_byte(8'd7, 3'd1);
    checks++; if (uo_out !== 8'hFE) begin errors++; $display("FAIL sub_lo: got %h expected FE", uo_out); end
    checks++; if (uio_out !== 8'h60) begin errors++; $display("FAIL sub_uio: got %h expected 60", uio_out); end
    strobe_byte(8'h00, 3'd0);
    strobe_byte(8'h5A, 3'd0);
    strobe_byte(8'h5A, 3'd4);
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL xor_lo: got %h expected 00", uo_out); end
    checks++; if (uio_out !== 8'hA0) begin errors++; $display("FAIL xor_uio: got %h expected A0", uio_out); end
    strobe_byte(8'h00, 3'd0);
  endtask

  task automatic test_mul;
    integer n;
    strobe_byte(8'hFF, 3'd0);
    ui_in = 8'hFF; uio_in = 8'h0F;
    tick;
    uio_in = 8'h00;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (uio_out[4] !== 1'b1) break;
      n++;
      tick;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL mul_busy_cycles: got %0d expected 8", n); end
    checks++; if (uio_out !== 8'h60) begin errors++; $display("FAIL mul_uio: got %h expected 60", uio_out); end
    checks++; if (uo_out !== 8'h01) begin errors++; $display("FAIL mul_lo: got %h expected 01", uo_out); end
    uio_in = 8'h08; #1;
    checks++; if (uo_out !== 8'hFE) begin errors++; $display("FAIL mul_hi: got %h expected FE", uo_out); end
    uio_in = 8'h00; #1;
    strobe_byte(8'h00, 3'd0);
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL mul_ack_uo: got %h expected 00", uo_out); end
    checks++; if (uio_out !== 8'h40) begin errors++; $display("FAIL mul_ack_uio: got %h expected 40", uio_out); end
  endtask

  task automatic test_reset_mid_mul;
    strobe_byte(8'hFF, 3'd0);
    ui_in = 8'hFF; uio_in = 8'h0F;
    tick;
    uio_in = 8'h00;
    tick; tick; tick;
    checks++; if (uio_out !== 8'h50) begin errors++; $display("FAIL midmul_uio: got %h expected 50", uio_out); end
    rst_n = 1'b0;
    #1;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL midrst_uo: got %h expected 00", uo_out); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL midrst_uio_out: got %h expected 00", uio_out); end
    checks++; if (uio_oe !== 8'hF0) begin errors++; $display("FAIL midrst_uio_oe: got %h expected F0", uio_oe); end
    tick;
    rst_n = 1'b1;
    tick;
    strobe_byte(8'd1, 3'd0);
    strobe_byte(8'd1, 3'd0);
    checks++; if (uo_out !== 8'h02) begin errors++; $display("FAIL postrst_add: got %h expected 02", uo_out); end
    checks++; if (uio_out !== 8'h20) begin errors++; $display("FAIL postrst_uio: got %h expected 20", uio_out); end
    strobe_byte(8'h00, 3'd0);
  endtask

  task automatic test_held_strobe;
    ui_in = 8'h81; uio_in = 8'h01;
    repeat (5) tick;
    checks++; if (uio_out[5:4] !== 2'b00) begin errors++; $display("FAIL held_state: got %b expected 00", uio_out[5:4]); end
    uio_in = 8'h00;
    tick;
    strobe_byte(8'h03, 3'd5);
    checks++; if (uo_out !== 8'h08) begin errors++; $display("FAIL shl_lo: got %h expected 08", uo_out); end
    checks++; if (uio_out !== 8'h20) begin errors++; $display("FAIL shl_uio: got %h expected 20", uio_out); end
    strobe_byte(8'h00, 3'd0);
  endtask

  task automatic test_ena_freeze;
    integer n;
    strobe_byte(8'd3, 3'd0);
    ui_in = 8'd4; uio_in = 8'h0F;
    tick;
    uio_in = 8'h00;
    n = 1;
    for (int i = 1; i < 30; i++) begin
      ena = (i >= 4 && i < 7) ? 1'b0 : 1'b1;
      tick;
      if (uio_out[4] !== 1'b1) break;
      n++;
    end
    ena = 1'b1;
    checks++; if (n !== 11) begin errors++; $display("FAIL ena_busy_cycles: got %0d expected 11", n); end
    checks++; if (uo_out !== 8'h0C) begin errors++; $display("FAIL ena_mul_lo: got %h expected 0C", uo_out); end
    uio_in = 8'h08; #1;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL ena_mul_hi: got %h expected 00", uo_out); end
    checks++; if (uio_out !== 8'h20) begin errors++; $display("FAIL ena_mul_uio: got %h expected 20", uio_out); end
    // Strobe rising together with ena falling must not acknowledge.
    ena = 1'b0; uio_in = 8'h01;
    tick;
    uio_in = 8'h00;
    tick;
    ena = 1'b1;
    tick;
    checks++; if (uio_out[5] !== 1'b1) begin errors++; $display("FAIL ena_strobe_ignored: got %b expected 1", uio_out[5]); end
    strobe_byte(8'h00, 3'd0);
    checks++; if (uio_out[5:4] !== 2'b00) begin errors++; $display("FAIL ena_ack: got %b expected 00", uio_out[5:4]); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub_xor;
    test_mul;
    test_reset_mid_mul;
    test_held_strobe;
    test_ena_freeze;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
